// File: rtl/clock_broadcast_reset_sequencer.sv
// Per-domain reset release sequencer for a clock/reset broadcast node.
// After the source reset deasserts, every domain is held for one slot, then
// released one per slot in ascending index order. Once idle, a valid/ready
// request re-asserts reset on a subset of domains and replays the same
// hold-then-stagger release for just that subset.
module clock_broadcast_reset_sequencer #(
  parameter int N_OUT          = 4,
  parameter int STAGGER_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  output logic [N_OUT-1:0] out_reset,
  output logic             seq_done,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [N_OUT-1:0] req_mask,
  output logic             busy
);

  localparam int CNT_W = $clog2(STAGGER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [N_OUT-1:0] MASK_ZERO = {N_OUT{1'b0}};
  localparam logic [N_OUT-1:0] MASK_ONES = {N_OUT{1'b1}};

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [N_OUT-1:0] pend_r, pend_s;
  logic [N_OUT-1:0] out_reset_r, out_reset_s;
  logic             seq_done_r, seq_done_s;
  logic             req_ready_r, req_ready_s;
  logic             busy_r, busy_s;
  logic             slot_end_s;
  logic             accept_s;
  logic [N_OUT-1:0] rel_s;

  // One-hot of the lowest set bit: the next domain due for release.
  function automatic logic [N_OUT-1:0] lowest_set(input logic [N_OUT-1:0] m);
    return m & (~m + N_OUT'(1'b1));
  endfunction

  // Next-state and next-output logic for the hold/release/done sequence.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    pend_s      = pend_r;
    out_reset_s = out_reset_r;
    seq_done_s  = seq_done_r;
    slot_end_s  = (cnt_r == CNT_LAST);
    accept_s    = req_valid && req_ready_r;
    rel_s       = lowest_set(pend_r);

    case (state_r)
      ST_HOLD: begin
        if (slot_end_s) begin
          state_s = ST_RELEASE;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_RELEASE: begin
        if (slot_end_s) begin
          cnt_s       = CNT_ZERO;
          out_reset_s = out_reset_r & ~rel_s;
          pend_s      = pend_r & ~rel_s;
          if (pend_s == MASK_ZERO) begin
            state_s    = ST_DONE;
            seq_done_s = 1'b1;
          end else begin
            state_s = ST_RELEASE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DONE: begin
        cnt_s = CNT_ZERO;
        // A zero mask completes the handshake but changes nothing.
        if (accept_s && (req_mask != MASK_ZERO)) begin
          state_s     = ST_HOLD;
          pend_s      = req_mask;
          out_reset_s = out_reset_r | req_mask;
          seq_done_s  = 1'b0;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        // Unreachable encoding: fall back to a full hold of every domain.
        state_s     = ST_HOLD;
        cnt_s       = CNT_ZERO;
        pend_s      = MASK_ONES;
        out_reset_s = MASK_ONES;
        seq_done_s  = 1'b0;
      end
    endcase

    req_ready_s = (state_s == ST_DONE);
    busy_s      = ~seq_done_s;
  end

  // State and registered outputs; reset holds every domain in reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_HOLD;
      cnt_r       <= CNT_ZERO;
      pend_r      <= MASK_ONES;
      out_reset_r <= MASK_ONES;
      seq_done_r  <= 1'b0;
      req_ready_r <= 1'b0;
      busy_r      <= 1'b1;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      pend_r      <= pend_s;
      out_reset_r <= out_reset_s;
      seq_done_r  <= seq_done_s;
      req_ready_r <= req_ready_s;
      busy_r      <= busy_s;
    end
  end

  assign out_reset = out_reset_r;
  assign seq_done  = seq_done_r;
  assign req_ready = req_ready_r;
  assign busy      = busy_r;

endmodule
